// File: rtl/conv_out_drain_if.sv
// Bundle of the conv2 map input handshake, the 8-bit pixel output stream and the sticky error flags.
// The drain uses the slave view; the surrounding engine/consumer (or a bench) uses the master view.
interface conv_out_drain_if #(
    parameter int OUT_H = 12,
    parameter int OUT_W = 11,
    parameter int DW    = 24
);
    logic                      in_valid;
    logic [3:0]                in_chan;
    logic [OUT_H*OUT_W*DW-1:0] in_map;
    logic                      in_ready;

    logic                      m_valid;
    logic                      m_ready;
    logic [7:0]                m_data;
    logic [3:0]                m_chan;
    logic                      m_last;
    logic                      m_frame_last;

    logic                      err_ovf;
    logic                      err_seq;

    modport slave (
        input  in_valid, in_chan, in_map, m_ready,
        output in_ready, m_valid, m_data, m_chan, m_last, m_frame_last, err_ovf, err_seq
    );

    modport master (
        output in_valid, in_chan, in_map, m_ready,
        input  in_ready, m_valid, m_data, m_chan, m_last, m_frame_last, err_ovf, err_seq
    );
endinterface

// File: rtl/conv_out_drain.sv
// Buffers one conv2 feature map per channel, then streams ReLU + right-shift requantised pixels in raster order.
// Define CONV_DRAIN_SAT_EN to saturate the requantised value at 255 instead of truncating to its low byte.
module conv_out_drain #(
    parameter int OUT_H = 12,
    parameter int OUT_W = 11,
    parameter int CHAN  = 10,
    parameter int DW    = 24,
    parameter int SHIFT = 8
) (
    input logic             clk,
    input logic             rst,
    conv_out_drain_if.slave bus
);

    localparam int         NPIX      = OUT_H * OUT_W;
    localparam int         MAPW      = NPIX * DW;
    localparam int         RW        = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int         CW        = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [3:0] LAST_CHAN = 4'(CHAN - 1);
    localparam logic       ONE_PIX   = (NPIX == 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [MAPW-1:0] pix_q;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [3:0]      chan_q;
    logic [3:0]      exp_chan_q;
    logic [7:0]      data_q;
    logic            last_q;
    logic            frame_last_q;
    logic            err_ovf_q;
    logic            err_seq_q;

    logic            ready_s;
    logic            valid_s;
    logic            capture;
    logic            advance;
    int              next_idx;
    logic            next_last;

    // Negative pixels clamp to zero; the rest keep the integer part after the shift.
    function automatic logic [7:0] quant(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        y = x >> SHIFT;
        if (x[DW-1]) begin
            return 8'd0;
        end
`ifdef CONV_DRAIN_SAT_EN
        if (|y[DW-1:8]) begin
            return 8'hFF;
        end
`endif
        return 8'(y);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = DRAIN;
            DRAIN:   if (bus.m_ready && last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_s = (state_q == IDLE);
        valid_s = (state_q == DRAIN);
        capture = ready_s && bus.in_valid;
        advance = valid_s && bus.m_ready && !last_q;
    end

    // Raster position of the pixel that follows the one currently presented.
    always_comb begin
        row_d = row_q;
        col_d = col_q + 1'b1;
        if (int'(col_q) == OUT_W - 1) begin
            col_d = '0;
            row_d = row_q + 1'b1;
        end
        next_idx  = int'(row_d) * OUT_W + int'(col_d);
        next_last = (int'(row_d) == OUT_H - 1) && (int'(col_d) == OUT_W - 1);
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            pix_q <= bus.in_map;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            chan_q       <= '0;
            data_q       <= '0;
            last_q       <= 1'b0;
            frame_last_q <= 1'b0;
        end else if (capture) begin
            row_q        <= '0;
            col_q        <= '0;
            chan_q       <= bus.in_chan;
            data_q       <= quant(bus.in_map[DW-1:0]);
            last_q       <= ONE_PIX;
            frame_last_q <= ONE_PIX && (bus.in_chan == LAST_CHAN);
        end else if (advance) begin
            row_q        <= row_d;
            col_q        <= col_d;
            data_q       <= quant(pix_q[next_idx*DW +: DW]);
            last_q       <= next_last;
            frame_last_q <= next_last && (chan_q == LAST_CHAN);
        end
    end

    // The expected channel follows whatever arrived, so one bad tag flags once and then resyncs.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_chan_q <= '0;
            err_ovf_q  <= 1'b0;
            err_seq_q  <= 1'b0;
        end else begin
            if (bus.in_valid && !ready_s) begin
                err_ovf_q <= 1'b1;
            end
            if (capture) begin
                if (bus.in_chan != exp_chan_q) begin
                    err_seq_q <= 1'b1;
                end
                exp_chan_q <= (bus.in_chan >= LAST_CHAN) ? 4'd0 : bus.in_chan + 4'd1;
            end
        end
    end

    assign bus.in_ready     = ready_s;
    assign bus.m_valid      = valid_s;
    assign bus.m_data       = data_q;
    assign bus.m_chan       = chan_q;
    assign bus.m_last       = last_q;
    assign bus.m_frame_last = frame_last_q;
    assign bus.err_ovf      = err_ovf_q;
    assign bus.err_seq      = err_seq_q;

endmodule
